amo_sequencer: RTL and testbench
================================

# amo_sequencer

Data-side memory controller between the core's data memory bus and the 64-bit RAM/ROM bus (MEMBUS_DATA_WIDTH = 64). It forwards ordinary loads and stores, and sequences A-extension operations (OP_AMO, AMOOp encodings) as load/compute/store transactions on the shared bus. It also holds the single LR/SC reservation. It issues at most one memory transaction at a time.

## Interface
- No parameters; widths come from eei (XLEN = 64, MEMBUS_DATA_WIDTH = 64).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- core_valid  input  1  core request valid.
- core_ready  output  1  block can accept a request; high only in IDLE.
- core_addr  input  64  byte address.
- core_wen  input  1  store (ignored when core_is_amo = 1).
- core_wdata  input  64  store data, or rs2 for AMO.
- core_wmask  input  8  byte-enable for plain stores.
- core_is_amo  input  1  request is an AMO.
- core_amo_op  input  5  AMOOp (funct5).
- core_amo_is_w  input  1  1 = .W (funct3 010), 0 = .D (funct3 011).
- core_rvalid  output  1  one-cycle response pulse.
- core_rdata  output  64  load data or AMO result.
- mem_valid / mem_ready  output / input  1  memory request handshake.
- mem_addr  output  64  request address, equal to the latched core_addr.
- mem_wen  output  1  write.
- mem_wdata  output  64  write data.
- mem_wmask  output  8  byte-enable.
- mem_rvalid  input  1  memory response pulse; exactly one per accepted request, at least 1 cycle after acceptance.
- mem_rdata  input  64  response data.

## Operation
- **States:** IDLE, REQ, WAIT, ST_REQ, ST_WAIT, RESP.
- **Accept:** in IDLE, `core_valid && core_ready` latches every core_* field.
  - Plain request, LR, or ordinary AMO → REQ.
  - SC → ST_REQ if the reservation hits, otherwise RESP with result 1.
- **REQ:** mem_valid = 1.
  - Plain request: fields are driven unchanged.
  - AMO/LR: the request is a read.
  - Move to WAIT on mem_ready.
- **WAIT:** on mem_rvalid:
  - Plain request or LR → RESP with mem_rdata captured.
  - Ordinary AMO → ST_REQ with the old value and the computed new value registered.
- **ST_REQ:** mem_valid = 1, mem_wen = 1. Move to ST_WAIT on mem_ready.
- **ST_WAIT:** on mem_rvalid → RESP.
- **RESP:** core_rvalid = 1 for exactly one cycle, then IDLE.
- **Lane rules (.W):**
  - The lane is addr[2]: 0 selects bits [31:0], 1 selects bits [63:32].
  - mem_wmask = 8'h0F or 8'hF0; mem_wdata = {new32, new32}.
  - Old value = selected lane, sign-extended to 64 bits. This value is the AMO result and the LR result.
- **.D rules:** mem_wmask = 8'hFF; full 64-bit operation.
- **Plain load result:** raw mem_rdata, with no extension.
- **Compute (old, rs2) at the operand width, 32 bits for .W:**
  - SWAP → rs2; ADD → sum modulo 2^width.
  - XOR / AND / OR → bitwise.
  - MIN / MAX → signed compare; MINU / MAXU → unsigned compare.
- **Reservation:** {valid, addr[63:3]}, one entry.
  - LR sets it when the load response arrives.
  - SC hit condition: valid and equal dword address. An SC hit stores rs2 (lane-masked for .W) and returns result 0.
  - Any SC clears the reservation, whether it succeeds or fails.
  - Any plain store or AMO store whose dword matches the reservation clears it.
- **Misaligned addresses:** the core traps these (STORE_AMO_ADDRESS_MISALIGNED) before issue. Behaviour for a misaligned address at this block is unspecified.
- **Undefined funct5 values:** these are rejected as ILLEGAL_INSTRUCTION upstream.

## Timing
- **Reset values:** every output is 0; state is IDLE; reservation invalid.
- **Reset mid-transaction:** the transaction is abandoned immediately and the block returns to IDLE. The memory side is reset by the same rst, so no stale mem_rvalid can follow.
- **Plain request or LR:**
  - Accept at cycle T.
  - mem_valid from T+1 until the handshake.
  - core_rvalid one cycle after mem_rvalid.
- **Ordinary AMO:**
  - Load phase as above.
  - ST_REQ is entered the cycle after the load's mem_rvalid.
  - core_rvalid one cycle after the store's mem_rvalid.
- **SC fail:** accept at T, core_rvalid at T+1, no memory traffic.
- **Request stability:** while mem_valid = 1 and mem_ready = 0, mem_addr, mem_wen, mem_wdata and mem_wmask stay stable.
- **Ignored inputs:**
  - core_valid outside IDLE is ignored.
  - mem_rvalid outside WAIT and ST_WAIT is ignored.

## Test plan
- Plain load at 0x8000_0000, memory holds 0x1122334455667788, memory response latency 2 → one read, core_rdata = 0x1122334455667788, core_rvalid exactly 1 cycle after mem_rvalid.
- AMOADD.D at 0x8000_0008, memory = 5, rs2 = 7 → read, then write with wdata = 12 and mask FF; core_rdata = 5; memory now holds 12.
- AMOMIN.W at 0x8000_0004, upper lane = 0xFFFFFFFF, rs2 = 3 → stores 0xFFFFFFFF with mask F0, result 0xFFFFFFFFFFFFFFFF. AMOMINU.W with the same setup → stores 3, result 0xFFFFFFFFFFFFFFFF.
- LR.D 0x8000_0010, then SC.D 0x8000_0010 with rs2 = 9 → store 9, result 0. A second SC.D to the same address → no mem_valid, result 1, core_rvalid at T+1.
- LR.W 0x8000_0014, then plain store (mask F0) to 0x8000_0014, then SC.W → SC fails with result 1; memory unchanged by the SC.
- mem_ready held low for 3 cycles in ST_REQ → request fields stable throughout. rst asserted during WAIT → all outputs 0 asynchronously, reservation cleared; a following SC returns 1.

Source files
------------

// File: rtl/amo_sequencer.sv
// Data-side sequencer: forwards loads/stores to the 64-bit memory bus and runs AMO/LR/SC as read-modify-write.
// Latency: plain/LR response one cycle after mem_rvalid; AMO adds a store phase. One transaction at a time; core_ready only in IDLE.
// Backpressure: mem_valid holds request fields stable until mem_ready; core requests are refused outside IDLE.
module amo_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [63:0] core_addr,
  input  logic        core_wen,
  input  logic [63:0] core_wdata,
  input  logic [7:0]  core_wmask,
  input  logic        core_is_amo,
  input  logic [4:0]  core_amo_op,
  input  logic        core_amo_is_w,
  output logic        core_rvalid,
  output logic [63:0] core_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    ST_REQ  = 3'd3,
    ST_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        out_en_q;
  logic [63:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        is_amo_q;
  logic [4:0]  op_q;
  logic        is_w_q;
  logic [63:0] result_q;
  logic [63:0] new_q;
  logic        resv_vld_q;
  logic [60:0] resv_dw_q;

  logic        accept;
  logic        in_is_sc;
  logic        in_resv_hit;
  logic        is_lr_q;
  logic        is_sc_q;
  logic        is_rmw_q;
  logic [31:0] old_lane;
  logic [63:0] old_ext;
  logic [63:0] rs2_ext;
  logic [63:0] alu;
  logic [7:0]  lane_mask;
  logic [63:0] st_data;

  assign accept      = core_valid && core_ready;
  assign in_is_sc    = core_is_amo && (core_amo_op == OP_SC);
  assign in_resv_hit = resv_vld_q && (resv_dw_q == core_addr[63:3]);
  assign is_lr_q     = is_amo_q && (op_q == OP_LR);
  assign is_sc_q     = is_amo_q && (op_q == OP_SC);
  assign is_rmw_q    = is_amo_q && !is_lr_q && !is_sc_q;

  // .W operands are sign-extended so one 64-bit ALU serves both widths;
  // sign extension preserves unsigned ordering, and only new[31:0] is stored.
  assign old_lane = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign old_ext  = is_w_q ? {{32{old_lane[31]}}, old_lane} : mem_rdata;
  assign rs2_ext  = is_w_q ? {{32{wdata_q[31]}}, wdata_q[31:0]} : wdata_q;

  always_comb begin
    alu = rs2_ext;
    case (op_q)
      OP_SWAP: alu = rs2_ext;
      OP_ADD:  alu = old_ext + rs2_ext;
      OP_XOR:  alu = old_ext ^ rs2_ext;
      OP_AND:  alu = old_ext & rs2_ext;
      OP_OR:   alu = old_ext | rs2_ext;
      OP_MIN:  alu = ($signed(old_ext) < $signed(rs2_ext)) ? old_ext : rs2_ext;
      OP_MAX:  alu = ($signed(old_ext) > $signed(rs2_ext)) ? old_ext : rs2_ext;
      OP_MINU: alu = (old_ext < rs2_ext) ? old_ext : rs2_ext;
      OP_MAXU: alu = (old_ext > rs2_ext) ? old_ext : rs2_ext;
      default: alu = rs2_ext;
    endcase
  end

  assign lane_mask = is_w_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;
  assign st_data   = is_w_q ? {new_q[31:0], new_q[31:0]} : new_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_sc) state_d = in_resv_hit ? ST_REQ : RESP;
          else          state_d = REQ;
        end
      end
      REQ:     if (mem_ready)  state_d = WAIT;
      WAIT:    if (mem_rvalid) state_d = is_rmw_q ? ST_REQ : RESP;
      ST_REQ:  if (mem_ready)  state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are zero outside their active states so reset forces every output low.
  always_comb begin
    core_ready  = (state_q == IDLE) && out_en_q;
    core_rvalid = (state_q == RESP);
    core_rdata  = (state_q == RESP) ? result_q : 64'd0;
    mem_valid   = 1'b0;
    mem_addr    = 64'd0;
    mem_wen     = 1'b0;
    mem_wdata   = 64'd0;
    mem_wmask   = 8'd0;
    case (state_q)
      REQ: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q;
        if (!is_amo_q) begin
          mem_wen   = wen_q;
          mem_wdata = wdata_q;
          mem_wmask = wmask_q;
        end
      end
      ST_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q;
        mem_wen   = 1'b1;
        mem_wdata = st_data;
        mem_wmask = lane_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_en_q <= 1'b0;
      addr_q   <= 64'd0;
      wen_q    <= 1'b0;
      wdata_q  <= 64'd0;
      wmask_q  <= 8'd0;
      is_amo_q <= 1'b0;
      op_q     <= 5'd0;
      is_w_q   <= 1'b0;
      result_q <= 64'd0;
      new_q    <= 64'd0;
    end else begin
      out_en_q <= 1'b1;
      if (accept) begin
        addr_q   <= core_addr;
        wen_q    <= core_wen;
        wdata_q  <= core_wdata;
        wmask_q  <= core_wmask;
        is_amo_q <= core_is_amo;
        op_q     <= core_amo_op;
        is_w_q   <= core_amo_is_w;
        if (in_is_sc) begin
          new_q    <= core_wdata;
          result_q <= {63'd0, !in_resv_hit};
        end
      end else if (state_q == WAIT && mem_rvalid) begin
        if (is_rmw_q) begin
          result_q <= old_ext;
          new_q    <= alu;
        end else if (is_lr_q) begin
          result_q <= old_ext;
        end else begin
          result_q <= mem_rdata;
        end
      end
    end
  end

  // Single reservation: any SC, or any store hitting the reserved dword, drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resv_vld_q <= 1'b0;
      resv_dw_q  <= 61'd0;
    end else if (accept) begin
      if (in_is_sc || (!core_is_amo && core_wen && in_resv_hit)) resv_vld_q <= 1'b0;
    end else if (state_q == WAIT && mem_rvalid) begin
      if (is_lr_q) begin
        resv_vld_q <= 1'b1;
        resv_dw_q  <= addr_q[63:3];
      end else if (is_rmw_q && resv_dw_q == addr_q[63:3]) begin
        resv_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer with a byte-masked 8-dword memory model on the bus side.
module tb_amo_sequencer;

  localparam logic [4:0] ADD = 5'd0, SWAP = 5'd1, LR = 5'd2, SC = 5'd3, XOR = 5'd4;
  localparam logic [4:0] OR_ = 5'd8, AND_ = 5'd12, MIN = 5'd16, MAX = 5'd20;
  localparam logic [4:0] MINU = 5'd24, MAXU = 5'd28;

  logic        clk, rst;
  logic        core_valid, core_ready;
  logic [63:0] core_addr;
  logic        core_wen;
  logic [63:0] core_wdata;
  logic [7:0]  core_wmask;
  logic        core_is_amo;
  logic [4:0]  core_amo_op;
  logic        core_amo_is_w;
  logic        core_rvalid;
  logic [63:0] core_rdata;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  amo_sequencer dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
    .core_wen(core_wen), .core_wdata(core_wdata), .core_wmask(core_wmask),
    .core_is_amo(core_is_amo), .core_amo_op(core_amo_op), .core_amo_is_w(core_amo_is_w),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_amo;
    logic [4:0]  op;
    logic        is_w;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        pre_en;
    logic [63:0] pre;
    int          stall;
    int          exp_nrd;
    int          exp_nwr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_rdata;
    logic [63:0] exp_mem;
  } vec_t;

  logic [63:0] mem [8];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic is_amo, input logic [4:0] op, input logic is_w,
                              input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [7:0] wmask, input logic pre_en, input logic [63:0] pre,
                              input int stall, input int nrd, input int nwr,
                              input logic [63:0] ewd, input logic [7:0] ewm,
                              input logic [63:0] erd, input logic [63:0] emem);
    vec_t v;
    v.is_amo = is_amo; v.op = op; v.is_w = is_w; v.wen = wen; v.addr = addr;
    v.wdata = wdata; v.wmask = wmask; v.pre_en = pre_en; v.pre = pre; v.stall = stall;
    v.exp_nrd = nrd; v.exp_nwr = nwr; v.exp_wdata = ewd; v.exp_wmask = ewm;
    v.exp_rdata = erd; v.exp_mem = emem;
    return v;
  endfunction

  // Drives one core request and plays the memory side: optional stall before mem_ready,
  // response pulse one cycle after the handshake-observing negedge.
  task automatic run_row(input string nm, input vec_t v);
    logic [63:0] bm, snap_a, snap_d;
    logic [9:0]  snap_c;
    logic [63:0] rsp, got, last_wd;
    logic [7:0]  last_wm;
    int          idx, nrd, nwr, stall_left, ref_n, resp_n;
    bit          armed, rv_pend, seen, stable, done;
    idx = int'(v.addr[5:3]);
    if (v.pre_en) mem[idx] = v.pre;
    nrd = 0; nwr = 0; stall_left = v.stall; ref_n = -1; resp_n = -100;
    armed = 0; rv_pend = 0; seen = 0; stable = 1; done = 0;
    rsp = 0; got = 0; last_wd = 0; last_wm = 0;
    snap_a = 0; snap_d = 0; snap_c = 0;
    @(negedge clk);
    chk({nm, " core_ready"}, {63'd0, core_ready}, 64'd1);
    core_valid = 1; core_addr = v.addr; core_wen = v.wen; core_wdata = v.wdata;
    core_wmask = v.wmask; core_is_amo = v.is_amo; core_amo_op = v.op; core_amo_is_w = v.is_w;
    @(negedge clk);
    core_valid = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      if (n > 0) @(negedge clk);
      mem_rvalid = 0;
      if (core_rvalid) begin
        got = core_rdata; resp_n = n; done = 1;
      end else if (armed) begin
        mem_ready = 0; armed = 0; rv_pend = 1;
      end else if (rv_pend) begin
        rv_pend = 0; mem_rvalid = 1; mem_rdata = rsp; ref_n = n;
      end else if (mem_valid) begin
        if (!seen) begin
          snap_a = mem_addr; snap_d = mem_wdata; snap_c = {mem_wen, mem_wmask, 1'b0};
          seen = 1;
        end else if (mem_addr !== snap_a || mem_wdata !== snap_d ||
                     {mem_wen, mem_wmask, 1'b0} !== snap_c) begin
          stable = 0;
        end
        if (stall_left > 0) stall_left--;
        else begin
          mem_ready = 1; armed = 1; seen = 0; stall_left = v.stall;
          for (int b = 0; b < 8; b++) bm[8*b +: 8] = {8{mem_wmask[b]}};
          if (mem_wen) begin
            mem[int'(mem_addr[5:3])] = (mem[int'(mem_addr[5:3])] & ~bm) | (mem_wdata & bm);
            rsp = 0; nwr++; last_wd = mem_wdata; last_wm = mem_wmask;
          end else begin
            rsp = mem[int'(mem_addr[5:3])]; nrd++;
          end
        end
      end
    end
    mem_rvalid = 0; mem_ready = 0;
    chk({nm, " responded"}, {63'd0, done}, 64'd1);
    chk({nm, " rdata"}, got, v.exp_rdata);
    chk({nm, " resp_latency"}, 64'(resp_n - ref_n), 64'd1);
    @(negedge clk);
    chk({nm, " rvalid_pulse"}, {63'd0, core_rvalid}, 64'd0);
    chk({nm, " reads"}, 64'(nrd), 64'(v.exp_nrd));
    chk({nm, " writes"}, 64'(nwr), 64'(v.exp_nwr));
    if (v.exp_nwr > 0) begin
      chk({nm, " wdata"}, last_wd, v.exp_wdata);
      chk({nm, " wmask"}, {56'd0, last_wm}, {56'd0, v.exp_wmask});
    end
    chk({nm, " mem"}, mem[idx], v.exp_mem);
    if (v.stall > 0) chk({nm, " req_stable"}, {63'd0, stable}, 64'd1);
  endtask

  vec_t tv[17];
  vec_t sc_after_rst;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 64'd0;
    rst = 0; core_valid = 0; core_addr = 0; core_wen = 0; core_wdata = 0; core_wmask = 0;
    core_is_amo = 0; core_amo_op = 0; core_amo_is_w = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;

    //          amo op    w  wen addr               wdata                  wm     pre pre-value              st rd wr exp wdata              wm     exp rdata              exp mem
    tv[0]  = mk(0, ADD,  0, 0, 64'h8000_0000, 64'h0,                 8'h00, 1, 64'h1122334455667788, 0, 1, 0, 64'h0,                 8'h00, 64'h1122334455667788, 64'h1122334455667788);
    tv[1]  = mk(1, ADD,  0, 0, 64'h8000_0008, 64'd7,                 8'h00, 1, 64'd5,                3, 1, 1, 64'd12,                8'hFF, 64'd5,                64'd12);
    tv[2]  = mk(1, MIN,  1, 0, 64'h8000_0004, 64'd3,                 8'h00, 1, 64'hFFFFFFFF_12345678, 0, 1, 1, 64'hFFFFFFFF_FFFFFFFF, 8'hF0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_12345678);
    tv[3]  = mk(1, MINU, 1, 0, 64'h8000_0004, 64'd3,                 8'h00, 1, 64'hFFFFFFFF_12345678, 0, 1, 1, 64'h00000003_00000003, 8'hF0, 64'hFFFFFFFF_FFFFFFFF, 64'h00000003_12345678);
    tv[4]  = mk(1, LR,   0, 0, 64'h8000_0010, 64'h0,                 8'h00, 1, 64'hAAAA,             0, 1, 0, 64'h0,                 8'h00, 64'hAAAA,             64'hAAAA);
    tv[5]  = mk(1, SC,   0, 0, 64'h8000_0010, 64'd9,                 8'h00, 0, 64'h0,                3, 0, 1, 64'd9,                 8'hFF, 64'd0,                64'd9);
    tv[6]  = mk(1, SC,   0, 0, 64'h8000_0010, 64'd4,                 8'h00, 0, 64'h0,                0, 0, 0, 64'h0,                 8'h00, 64'd1,                64'd9);
    tv[7]  = mk(1, LR,   1, 0, 64'h8000_0014, 64'h0,                 8'h00, 1, 64'h80000001_00000002, 0, 1, 0, 64'h0,                 8'h00, 64'hFFFFFFFF_80000001, 64'h80000001_00000002);
    tv[8]  = mk(0, ADD,  0, 1, 64'h8000_0014, 64'h55555555_AAAAAAAA, 8'hF0, 0, 64'h0,                0, 0, 1, 64'h55555555_AAAAAAAA, 8'hF0, 64'd0,                64'h55555555_00000002);
    tv[9]  = mk(1, SC,   1, 0, 64'h8000_0014, 64'd7,                 8'h00, 0, 64'h0,                0, 0, 0, 64'h0,                 8'h00, 64'd1,                64'h55555555_00000002);
    tv[10] = mk(1, SWAP, 1, 0, 64'h8000_0018, 64'hDEADBEEF_CAFEF00D, 8'h00, 1, 64'h11111111_22222222, 0, 1, 1, 64'hCAFEF00D_CAFEF00D, 8'h0F, 64'h00000000_22222222, 64'h11111111_CAFEF00D);
    tv[11] = mk(1, ADD,  1, 0, 64'h8000_001C, 64'd1,                 8'h00, 1, 64'h7FFFFFFF_00000000, 0, 1, 1, 64'h80000000_80000000, 8'hF0, 64'h00000000_7FFFFFFF, 64'h80000000_00000000);
    tv[12] = mk(1, MAX,  0, 0, 64'h8000_0020, 64'd3,                 8'h00, 1, 64'hFFFFFFFF_FFFFFFFE, 0, 1, 1, 64'd3,                 8'hFF, 64'hFFFFFFFF_FFFFFFFE, 64'd3);
    tv[13] = mk(1, MAXU, 0, 0, 64'h8000_0020, 64'hFFFFFFFF_FFFFFFFE, 8'h00, 0, 64'h0,                0, 1, 1, 64'hFFFFFFFF_FFFFFFFE, 8'hFF, 64'd3,                64'hFFFFFFFF_FFFFFFFE);
    tv[14] = mk(1, XOR,  0, 0, 64'h8000_0028, 64'h0FF0,              8'h00, 1, 64'hF0F0,             0, 1, 1, 64'hFF00,              8'hFF, 64'hF0F0,             64'hFF00);
    tv[15] = mk(1, AND_, 1, 0, 64'h8000_0028, 64'h0F0F0F0F,          8'h00, 0, 64'h0,                0, 1, 1, 64'h00000F00_00000F00, 8'h0F, 64'hFF00,             64'h0F00);
    tv[16] = mk(1, OR_,  0, 0, 64'h8000_0030, 64'h80000000_00000000, 8'h00, 1, 64'd1,                0, 1, 1, 64'h80000000_00000001, 8'hFF, 64'd1,                64'h80000000_00000001);

    #12;
    chk("reset_outputs", {core_ready, core_rvalid, mem_valid, mem_wen, mem_wmask, 48'd0} | core_rdata | mem_addr | mem_wdata, 64'd0);
    @(negedge clk);
    rst = 1;

    for (int r = 0; r < 17; r++) run_row($sformatf("row%0d", r), tv[r]);

    // LR sets the reservation, then reset lands while an AMO waits on its read response.
    run_row("lr_before_rst", mk(1, LR, 0, 0, 64'h8000_0038, 64'h0, 8'h00, 1, 64'h77, 0, 1, 0, 64'h0, 8'h00, 64'h77, 64'h77));
    @(negedge clk);
    core_valid = 1; core_addr = 64'h8000_0038; core_wen = 0; core_wdata = 64'd1;
    core_is_amo = 1; core_amo_op = ADD; core_amo_is_w = 0;
    @(negedge clk);
    core_valid = 0;
    for (int n = 0; n < 10 && !mem_valid; n++) @(negedge clk);
    chk("rst_seq mem_valid", {63'd0, mem_valid}, 64'd1);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    #2 rst = 0;
    #1;
    chk("rst_mid outputs", {core_ready, core_rvalid, mem_valid, mem_wen, mem_wmask, 48'd0} | core_rdata | mem_addr | mem_wdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    sc_after_rst = mk(1, SC, 0, 0, 64'h8000_0038, 64'd5, 8'h00, 0, 64'h0, 0, 0, 0, 64'h0, 8'h00, 64'd1, 64'h77);
    run_row("sc_after_rst", sc_after_rst);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
